// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the multiply/divide unit.
//   mdu_op_t      - HI/LO-class op codes presented by the EX stage
//   mdu_state_t   - sequencer states
//   is_mdu_multi  - true for ops that occupy the unit for several cycles
//   is_mdu_valid  - true for any recognised op code (others are no-ops)
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_mdu_multi(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_mdu_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring divider on unsigned magnitudes.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   load              - capture dividend/divisor and clear the partial remainder
//   dividend, divisor - unsigned operands
//   step              - perform one restoring step (one quotient bit) this cycle
//   quotient          - quotient after the step being taken this cycle
//   remainder         - remainder after the step being taken this cycle
// The outputs look one step ahead so the sequencer can commit the final
// result on the same edge that performs the last iteration.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             step,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;

    // The partial remainder is one bit wider than the operands so the sign
    // of the trial subtraction tells us whether to restore.
    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, dvs_q};
        if (diff[WIDTH]) begin
            remainder = partial[WIDTH-1:0];
            quotient  = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            remainder = diff[WIDTH-1:0];
            quotient  = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // quo_q starts as the dividend and fills with quotient bits from the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer beside the EX-stage ALU.
// Owns HI/LO, runs mult/multu as a counted fixed-latency op and div/divu as
// a radix-2 restoring loop, and stalls the front of the pipe while busy.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, mdu_op     - EX stage presents an MDU op this cycle
//   src_a, src_b      - rs / rt operand values
//   flush             - squash the EX instruction and abort any in-flight op
//   stall             - hold IF/ID/EX (request arrived while busy)
//   busy              - multi-cycle op in flight
//   hi_out, lo_out    - current HI / LO
//   rd_data, rd_valid - mfhi/mflo result, combinational in the issue cycle
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mul_a_q, mul_b_q;
    logic               mul_signed_q;
    logic               neg_quo_q, neg_rem_q, div_zero_q;

    logic               accept, mul_load, div_load;
    logic               div_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, product;
    logic [WIDTH-1:0]   div_quo, div_rem, quo_fix, rem_fix;

    // A request is taken whenever no multi-cycle op is running, including the
    // DONE cycle, which gives back-to-back issue. Flush kills the request.
    always_comb begin
        busy     = (state_q == MUL) || (state_q == DIV);
        accept   = start && !flush && is_mdu_valid(mdu_op) && !busy;
        stall    = start && !flush && is_mdu_valid(mdu_op) && busy;
        mul_load = accept && ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU));
        div_load = accept && ((mdu_op == OP_DIV) || (mdu_op == OP_DIVU));
        rd_valid = accept && ((mdu_op == OP_MFHI) || (mdu_op == OP_MFLO));
        rd_data  = '0;
        if (rd_valid) begin
            rd_data = (mdu_op == OP_MFHI) ? hi_q : lo_q;
        end
    end

    // Divider works on magnitudes; the signs are remembered for the fixup.
    // |0x80000000| wraps to itself, which gives the required overflow result.
    always_comb begin
        div_signed = (mdu_op == OP_DIV);
        a_neg      = div_signed && src_a[WIDTH-1];
        b_neg      = div_signed && src_b[WIDTH-1];
        abs_a      = a_neg ? -src_a : src_a;
        abs_b      = b_neg ? -src_b : src_b;
    end

    mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .step      (state_q == DIV),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign- or zero-extending to 2*WIDTH lets one unsigned multiplier produce
    // both signed and unsigned products; the countdown gives it time to settle.
    // With a zero divisor the magnitude remainder is |a|, so the fixup below
    // restores src_a for HI while LO is forced to all ones.
    always_comb begin
        mul_ext_a = mul_signed_q ? {{WIDTH{mul_a_q[WIDTH-1]}}, mul_a_q} : {{WIDTH{1'b0}}, mul_a_q};
        mul_ext_b = mul_signed_q ? {{WIDTH{mul_b_q[WIDTH-1]}}, mul_b_q} : {{WIDTH{1'b0}}, mul_b_q};
        product   = mul_ext_a * mul_ext_b;
        quo_fix   = div_zero_q ? {WIDTH{1'b1}} : (neg_quo_q ? -div_quo : div_quo);
        rem_fix   = neg_rem_q ? -div_rem : div_rem;
    end

    // Next-state and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (mul_load) begin
                    state_d = MUL;
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                end else if (div_load) begin
                    state_d = DIV;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end else if (accept && (mdu_op == OP_MTHI)) begin
                    hi_d = src_a;
                end else if (accept && (mdu_op == OP_MTLO)) begin
                    lo_d = src_a;
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, HI/LO and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (mul_load) begin
                mul_a_q      <= src_a;
                mul_b_q      <= src_b;
                mul_signed_q <= (mdu_op == OP_MULT);
            end
            if (div_load) begin
                neg_quo_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (src_b == '0);
            end
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (WIDTH=32,
// MUL_CYCLES=4, DIV_CYCLES=32). Inputs change just after the falling edge and
// outputs are sampled there (plus #1 for combinational outputs).
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] rd_data;
    logic        rd_valid;

    int checks   = 0;
    int failures = 0;

    mdu_ctrl #(.WIDTH(32), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mdu_op   (mdu_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    // Issue one op for a single cycle, then count the cycles busy stays high
    // (bounded). Returns at the falling edge of the first non-busy cycle.
    task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; mdu_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mdu_op = 4'd0; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hi_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected %h", hi_out, 32'h0); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected %h", lo_out, 32'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, 32'h0); end
    endtask

    task automatic test_mult_signed();
        int n;
        issue_and_wait(4'd1, 32'hFFFF_FFFD, 32'd7, n);
        checks++; if (n !== 4) begin failures++; $display("[TB] FAIL mult_busy_cycles: got %0d expected 4", n); end
        checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
        checks++; if (lo_out !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mult_lo: got %h expected %h", lo_out, 32'hFFFF_FFEB); end
    endtask

    task automatic test_div_signed();
        int n;
        issue_and_wait(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 32) begin failures++; $display("[TB] FAIL div_busy_cycles: got %0d expected 32", n); end
        checks++; if (lo_out !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_lo: got %h expected %h", lo_out, 32'hFFFF_FFFD); end
        checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
    endtask

    task automatic test_divu();
        int n;
        issue_and_wait(4'd4, 32'd100, 32'd7, n);
        checks++; if (n !== 32) begin failures++; $display("[TB] FAIL divu_busy_cycles: got %0d expected 32", n); end
        checks++; if (lo_out !== 32'd14) begin failures++; $display("[TB] FAIL divu_lo: got %h expected %h", lo_out, 32'd14); end
        checks++; if (hi_out !== 32'd2) begin failures++; $display("[TB] FAIL divu_hi: got %h expected %h", hi_out, 32'd2); end
    endtask

    task automatic test_div_by_zero();
        int n;
        issue_and_wait(4'd3, 32'd5, 32'd0, n);
        checks++; if (n !== 32) begin failures++; $display("[TB] FAIL divzero_busy_cycles: got %0d expected 32", n); end
        checks++; if (lo_out !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divzero_lo: got %h expected %h", lo_out, 32'hFFFF_FFFF); end
        checks++; if (hi_out !== 32'd5) begin failures++; $display("[TB] FAIL divzero_hi: got %h expected %h", hi_out, 32'd5); end
    endtask

    task automatic test_div_overflow();
        int n;
        issue_and_wait(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (lo_out !== 32'h8000_0000) begin failures++; $display("[TB] FAIL divovf_lo: got %h expected %h", lo_out, 32'h8000_0000); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("[TB] FAIL divovf_hi: got %h expected %h", hi_out, 32'h0); end
    endtask

    // MFLO arrives one cycle after MULTU and is held by the EX stage until
    // the unit reaches DONE, where the fresh product is read.
    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd2; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
        @(negedge clk);
        mdu_op = 4'd6; src_a = '0; src_b = '0;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL b2b_stall_first: got %b expected 1", stall); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_rd_valid_stalled: got %b expected 0", rd_valid); end
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++; if (n !== 4) begin failures++; $display("[TB] FAIL b2b_stall_cycles: got %0d expected 4", n); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_rd_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL b2b_rd_data: got %h expected %h", rd_data, 32'hFFFF_FFFE); end
        checks++; if (hi_out !== 32'd1) begin failures++; $display("[TB] FAIL b2b_hi: got %h expected %h", hi_out, 32'd1); end
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
    endtask

    task automatic test_move_to_from();
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd7; src_a = 32'h0000_1234;
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL mthi_rd_valid: got %b expected 0", rd_valid); end
        @(negedge clk);
        mdu_op = 4'd5; src_a = '0;
        #1;
        checks++; if (hi_out !== 32'h0000_1234) begin failures++; $display("[TB] FAIL mthi_hi: got %h expected %h", hi_out, 32'h0000_1234); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL mfhi_rd_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'h0000_1234) begin failures++; $display("[TB] FAIL mfhi_rd_data: got %h expected %h", rd_data, 32'h0000_1234); end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL mfhi_stall: got %b expected 0", stall); end
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
    endtask

    // HI=0x1234 and LO=0xFFFFFFFE on entry; an aborted divide must not touch them.
    task automatic test_flush();
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd4; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        repeat (40) @(negedge clk);
        checks++; if (hi_out !== 32'h0000_1234) begin failures++; $display("[TB] FAIL flush_hi: got %h expected %h", hi_out, 32'h0000_1234); end
        checks++; if (lo_out !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL flush_lo: got %h expected %h", lo_out, 32'hFFFF_FFFE); end
        start = 1'b1; mdu_op = 4'd1; src_a = 32'd3; src_b = 32'd3; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_start_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd4; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hi_out !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_hi: got %h expected %h", hi_out, 32'h0); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_lo: got %h expected %h", lo_out, 32'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stall: got %b expected 0", stall); end
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd5;
        #1;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_mfhi_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_mfhi_data: got %h expected %h", rd_data, 32'h0); end
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_div_signed();
        test_divu();
        test_div_by_zero();
        test_div_overflow();
        test_back_to_back();
        test_move_to_from();
        test_flush();
        test_reset_mid_div();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
